repetition_source: RTL and testbench
====================================

# repetition_source

Stimulus generator for the `repetition` counter. It emits a configurable-length stream of FIELD_SIZE-bit words over a valid/ready handshake, containing exactly a programmed number of adjacent repeats, and issues the `clear` pulse the counter expects before each stream. It sits on the counter's input side, both in the self-checking bench and in on-chip BIST, so the expected count is known by construction rather than read from a file.

## Interface
- FIELD_SIZE, 16, word width; legal values 8, 16, 32.
- sys_clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a stream; ignored while busy.
- cfg_len  in  FIELD_SIZE  number of words in the stream.
- cfg_nreps  in  FIELD_SIZE  number of words that must equal their predecessor.
- cfg_seed  in  FIELD_SIZE  LFSR seed; value 0 is replaced by 1.
- clear_out  out  1  one-cycle clear to the sink; drives the counter's `clear`.
- valid  out  1  field holds a word.
- field  out  FIELD_SIZE  data word.
- ready  in  1  sink accepts the word this cycle.
- busy  out  1  high from the start-accept cycle through the DONE cycle.
- done  out  1  one-cycle pulse after the last word transfers.
- sat_err  out  1  sticky; cfg_nreps exceeded cfg_len-1 and was clamped. Cleared by the next accepted start.

## Operation
- Repeat definition: a word equal to the immediately previous transferred word. The first word of a stream is never a repeat.
- Start latch: on an accepted start, latch:
  - len = cfg_len;
  - reps = min(cfg_nreps, max(cfg_len,1)-1), setting sat_err if clamped;
  - LFSR state = seed.
- Fresh words come from a maximal-length Galois LFSR.
  - The first word is the seed.
  - Each later fresh word is the next LFSR state.
  - A repeat word re-emits the current value without stepping the LFSR.
  - Consecutive fresh words always differ, so no unintended repeats occur.
- Repeat placement uses a Bresenham accumulator `acc`, FIELD_SIZE+1 bits, reset to 0 at start, for candidates k = 1..len-1:
  - if acc + reps ≥ len-1, word k is a repeat and acc ← acc + reps − (len−1);
  - otherwise acc ← acc + reps.
  - Result: exactly `reps` repeats, evenly spread.
- State machine:
  - IDLE: start → CLEAR.
  - CLEAR: clear_out=1 for 1 cycle → STREAM if len>0, else DONE.
  - STREAM: on each transfer, increment the word count; when count reaches len → DONE.
  - DONE: done=1 for 1 cycle → IDLE.
- Handshake:
  - A transfer happens when valid && ready.
  - While valid && !ready, field holds stable.
  - valid never drops mid-stream.
  - The next word is presented in the cycle after a transfer (full throughput; back-to-back transfers allowed).
- Reset at any time returns to IDLE and aborts the stream with no done pulse.

## Timing
- Reset values: valid=0, field=0, clear_out=0, busy=0, done=0, sat_err=0, state IDLE.
- Start sampled in cycle t:
  - clear_out=1 at t+1;
  - valid=1 with word 0 at t+2.
- With ready held high, the last word transfers at t+1+len and done=1 at t+2+len.
- start asserted in DONE or while busy is ignored. A new stream may start from IDLE the cycle after DONE.
- cfg_* are sampled only on start; later changes have no effect on the current stream.

## Structure
- Package `repetition_pkg`:
  - state enum {IDLE, CLEAR, STREAM, DONE};
  - function lfsr_taps(width) returning Galois tap masks: 8→0xB8, 16→0xB400, 32→0x80200003.
- Sub-module `lfsr_step`: parameterised FIELD_SIZE, with ports load, seed, advance, state. Reusable by other stimulus blocks.
- Top level holds the FSM, counters, accumulator and output register.

## Test plan
- len=10, nreps=3, seed=0xACE1, ready=1 → 10 words, exactly 3 adjacent-equal pairs; connected `repetition` reports rep_rate=3; done at t+12.
- len=8, nreps=20 → sat_err=1, 7 repeats (all 8 words equal 0xACE1).
- len=0 → clear_out pulse, no valid, done at t+2.
- len=16, nreps=5, ready toggling randomly → field stable while stalled, exactly 16 transfers, 5 repeats.
- seed=0, len=4, nreps=0 → words 0x0001 then successive LFSR states, no repeats.
- reset asserted mid-stream after word 3 → next cycle valid=0, busy=0, no done; new start runs a full stream with sat_err cleared.

Source files
------------

// File: rtl/repetition_pkg.sv
// Shared types and helpers for the repetition stimulus source.
//   state_t    : sequencing states of the stream generator
//   lfsr_taps  : Galois tap mask for a maximal-length LFSR of the given width
package repetition_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  function automatic logic [31:0] lfsr_taps(input int width);
    case (width)
      8:       return 32'h0000_00B8;
      32:      return 32'h8020_0003;
      default: return 32'h0000_B400;
    endcase
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// Maximal-length Galois LFSR holding one FIELD_SIZE-bit state.
//   sys_clk : clock
//   reset   : synchronous active-high reset, state -> 0
//   load    : load seed (a zero seed becomes 1, since 0 is the lock-up state)
//   seed    : value loaded on load
//   advance : step to the next LFSR state (ignored when load is high)
//   state   : current LFSR state
import repetition_pkg::*;

module lfsr_step #(
  parameter int FIELD_SIZE = 16
) (
  input  logic                  sys_clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [FIELD_SIZE-1:0] seed,
  input  logic                  advance,
  output logic [FIELD_SIZE-1:0] state
);

  localparam logic [31:0]           TAPS_W = lfsr_taps(FIELD_SIZE);
  localparam logic [FIELD_SIZE-1:0] TAPS   = TAPS_W[FIELD_SIZE-1:0];
  localparam logic [FIELD_SIZE-1:0] ONE    = 1;

  logic [FIELD_SIZE-1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = (seed == '0) ? ONE : seed;
    end else if (advance) begin
      state_d = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) state_q <= '0;
    else       state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/repetition_source.sv
// Stimulus source for the repetition counter: after a one-cycle clear it
// streams cfg_len words over valid/ready, of which exactly reps (cfg_nreps
// clamped to len-1) equal their predecessor, spread evenly by a Bresenham
// accumulator. Fresh words come from an LFSR, so they never repeat by accident.
//   sys_clk, reset       : clock, synchronous active-high reset
//   start                : begin a stream (ignored unless idle)
//   cfg_len/nreps/seed   : stream configuration, sampled on start
//   clear_out            : one-cycle clear to the sink
//   valid, field, ready  : word handshake
//   busy, done           : activity flag, end-of-stream pulse
//   sat_err              : sticky flag, cfg_nreps was clamped
import repetition_pkg::*;

module repetition_source #(
  parameter int FIELD_SIZE = 16
) (
  input  logic                  sys_clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [FIELD_SIZE-1:0] cfg_len,
  input  logic [FIELD_SIZE-1:0] cfg_nreps,
  input  logic [FIELD_SIZE-1:0] cfg_seed,
  output logic                  clear_out,
  output logic                  valid,
  output logic [FIELD_SIZE-1:0] field,
  input  logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic                  sat_err
);

  localparam logic [FIELD_SIZE-1:0] ONE = 1;

  state_t                state_q, state_d;
  logic [FIELD_SIZE-1:0] len_q, len_d;
  logic [FIELD_SIZE-1:0] reps_q, reps_d;
  logic [FIELD_SIZE-1:0] cnt_q, cnt_d;
  logic [FIELD_SIZE:0]   acc_q, acc_d;
  logic                  valid_q, valid_d;
  logic                  sat_q, sat_d;

  logic                  lfsr_load, lfsr_adv;
  logic [FIELD_SIZE-1:0] lfsr_state;

  logic [FIELD_SIZE-1:0] cfg_lenm1;
  logic                  clamp;
  logic [FIELD_SIZE-1:0] cnt_inc;
  logic [FIELD_SIZE:0]   acc_sum;
  logic [FIELD_SIZE:0]   lenm1_ext;

  lfsr_step #(.FIELD_SIZE(FIELD_SIZE)) u_lfsr (
    .sys_clk (sys_clk),
    .reset   (reset),
    .load    (lfsr_load),
    .seed    (cfg_seed),
    .advance (lfsr_adv),
    .state   (lfsr_state)
  );

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    reps_d    = reps_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    valid_d   = valid_q;
    sat_d     = sat_q;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;

    // A zero-length stream allows no repeats, same as length one.
    cfg_lenm1 = (cfg_len == '0) ? '0 : cfg_len - ONE;
    clamp     = cfg_nreps > cfg_lenm1;
    cnt_inc   = cnt_q + ONE;
    // acc < len-1 and reps <= len-1, so the sum fits in FIELD_SIZE+1 bits.
    acc_sum   = acc_q + {1'b0, reps_q};
    lenm1_ext = {1'b0, len_q - ONE};

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = CLEAR;
          len_d     = cfg_len;
          reps_d    = clamp ? cfg_lenm1 : cfg_nreps;
          sat_d     = clamp;
          cnt_d     = '0;
          acc_d     = '0;
          lfsr_load = 1'b1;
        end
      end
      CLEAR: begin
        if (len_q != '0) begin
          state_d = STREAM;
          valid_d = 1'b1;
        end else begin
          state_d = DONE;
        end
      end
      STREAM: begin
        if (valid_q && ready) begin
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) begin
            valid_d = 1'b0;
            state_d = DONE;
          end else if (acc_sum >= lenm1_ext) begin
            // Next word is a repeat: hold the LFSR so field re-emits.
            acc_d = acc_sum - lenm1_ext;
          end else begin
            acc_d    = acc_sum;
            lfsr_adv = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      reps_q  <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      valid_q <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      reps_q  <= reps_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      valid_q <= valid_d;
      sat_q   <= sat_d;
    end
  end

  assign clear_out = (state_q == CLEAR);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign valid     = valid_q;
  assign field     = lfsr_state;
  assign sat_err   = sat_q;

endmodule

// File: tb/tb_repetition_source.sv
// Directed self-checking bench for repetition_source (FIELD_SIZE = 16).
// Expected word sequences are hand-computed from the 0xB400 Galois LFSR.
module tb_repetition_source;

  logic        sys_clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] cfg_len, cfg_nreps, cfg_seed;
  logic        clear_out, valid, ready, busy, done, sat_err;
  logic [15:0] field;

  int n_chk  = 0;
  int n_pass = 0;

  logic [15:0] exp_w[$];

  repetition_source #(.FIELD_SIZE(16)) dut (
    .sys_clk   (sys_clk),
    .reset     (reset),
    .start     (start),
    .cfg_len   (cfg_len),
    .cfg_nreps (cfg_nreps),
    .cfg_seed  (cfg_seed),
    .clear_out (clear_out),
    .valid     (valid),
    .field     (field),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .sat_err   (sat_err)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Runs one stream. k counts negedges after the start-sampling edge, so k=1
  // is the CLEAR cycle. exp_done_k=0 skips the done-latency check.
  task automatic run_stream(input int len, input int nreps, input int seed, input bit rnd,
                            input int exp_done_k, input bit exp_sat, input int exp_reps);
    int          k = 0;
    int          nxfer = 0;
    int          nrep = 0;
    bit          have_prev = 0;
    bit          stalled = 0;
    bit          got_done = 0;
    logic [15:0] prev_w = '0;
    logic [15:0] held = '0;

    @(negedge sys_clk);
    cfg_len   = len[15:0];
    cfg_nreps = nreps[15:0];
    cfg_seed  = seed[15:0];
    start     = 1'b1;
    ready     = 1'b1;
    @(negedge sys_clk);
    k = 1;
    start     = 1'b0;
    // Scramble config: must not affect the running stream.
    cfg_len   = 16'hFFFF;
    cfg_nreps = 16'h0000;
    cfg_seed  = 16'h1234;
    chk("clear_pulse", 32'(clear_out), 32'd1);
    chk("busy_in_clear", 32'(busy), 32'd1);
    chk("valid_in_clear", 32'(valid), 32'd0);
    chk("sat_err", 32'(sat_err), 32'(exp_sat));

    while (!got_done && k < 300) begin
      @(negedge sys_clk);
      k++;
      start = (k == 4);
      if (done) begin
        got_done = 1;
        start    = 1'b0;
      end else begin
        if (stalled) begin
          chk("stall_valid", 32'(valid), 32'd1);
          chk("stall_field", 32'(field), 32'(held));
        end
        ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (valid && ready) begin
          if (nxfer < exp_w.size()) chk("word", 32'(field), 32'(exp_w[nxfer]));
          if (have_prev && field == prev_w) nrep++;
          prev_w    = field;
          have_prev = 1;
          nxfer++;
          stalled   = 0;
        end else begin
          stalled = valid;
          held    = field;
        end
      end
    end

    chk("done_seen", 32'(got_done), 32'd1);
    if (exp_done_k > 0) chk("done_cycle", k, exp_done_k);
    chk("valid_in_done", 32'(valid), 32'd0);
    chk("xfer_count", nxfer, len);
    chk("repeat_count", nrep, exp_reps);

    // start in the DONE cycle must be ignored
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    chk("start_in_done_busy", 32'(busy), 32'd0);
    chk("start_in_done_clear", 32'(clear_out), 32'd0);
    chk("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    int ndone;
    reset     = 1'b1;
    start     = 1'b0;
    ready     = 1'b1;
    cfg_len   = '0;
    cfg_nreps = '0;
    cfg_seed  = '0;
    repeat (3) @(negedge sys_clk);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_field", 32'(field), 32'd0);
    chk("rst_clear", 32'(clear_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sat", 32'(sat_err), 32'd0);
    reset = 1'b0;
    @(negedge sys_clk);

    // len=10, nreps=3: repeats at words 3, 6, 9
    exp_w = '{16'hACE1, 16'hE270, 16'h7138, 16'h7138, 16'h389C,
              16'h1C4E, 16'h1C4E, 16'h0E27, 16'hB313, 16'hB313};
    run_stream(10, 3, 16'hACE1, 0, 12, 0, 3);

    // len=8, nreps=20: clamped to 7, every word the seed
    exp_w = '{16'hACE1, 16'hACE1, 16'hACE1, 16'hACE1,
              16'hACE1, 16'hACE1, 16'hACE1, 16'hACE1};
    run_stream(8, 20, 16'hACE1, 0, 10, 1, 7);

    // len=0: clear only, done at t+2; sat_err cleared by this start
    exp_w = {};
    run_stream(0, 0, 16'hACE1, 0, 2, 0, 0);

    // len=16, nreps=5 with random ready: repeats at 3, 6, 9, 12, 15
    exp_w = '{16'hACE1, 16'hE270, 16'h7138, 16'h7138, 16'h389C, 16'h1C4E,
              16'h1C4E, 16'h0E27, 16'hB313, 16'hB313, 16'hED89, 16'hC2C4,
              16'hC2C4, 16'h6162, 16'h30B1, 16'h30B1};
    run_stream(16, 5, 16'hACE1, 1, 0, 0, 5);

    // seed=0 is replaced by 1
    exp_w = '{16'h0001, 16'hB400, 16'h5A00, 16'h2D00};
    run_stream(4, 0, 0, 0, 6, 0, 0);

    // Reset mid-stream after word 3
    @(negedge sys_clk);
    cfg_len   = 16'd10;
    cfg_nreps = 16'd20;
    cfg_seed  = 16'hACE1;
    ready     = 1'b1;
    start     = 1'b1;
    @(negedge sys_clk);               // k=1, CLEAR
    start = 1'b0;
    repeat (5) @(negedge sys_clk);    // k=6, words 0..3 transferred
    chk("mid_valid", 32'(valid), 32'd1);
    chk("mid_sat", 32'(sat_err), 32'd1);
    reset = 1'b1;
    @(negedge sys_clk);
    chk("abort_valid", 32'(valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_field", 32'(field), 32'd0);
    chk("abort_sat", 32'(sat_err), 32'd0);
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      if (done || busy) ndone++;
    end
    chk("no_activity_after_abort", ndone, 0);

    exp_w = '{16'hACE1, 16'hE270, 16'h7138, 16'h7138, 16'h389C,
              16'h1C4E, 16'h1C4E, 16'h0E27, 16'hB313, 16'hB313};
    run_stream(10, 3, 16'hACE1, 0, 12, 0, 3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
